// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and fills IF/ID.
// Optional performance counters are enabled with `define IF_STAGE_PERF_CNT_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned IM_BYTES = 128,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] InstrAddr,
   input  logic [31:0] Instruction,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc_plus4,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid,
   output logic        addr_err
`ifdef IF_STAGE_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   // Keeps addresses word-aligned and inside the memory window in one AND.
   localparam logic [31:0] PC_MASK  = 32'(IM_BYTES - 1) & ~32'h0000_0003;
   localparam logic [31:0] IM_LIMIT = 32'(IM_BYTES);

   logic [31:0] pc_q, pc_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic        addr_err_q, addr_err_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = (pc_q + 32'd4) & PC_MASK;

   always_comb begin
      pc_d            = pc_q;
      ifid_pc_d       = ifid_pc_q;
      ifid_pc_plus4_d = ifid_pc_plus4_q;
      ifid_instr_d    = ifid_instr_q;
      ifid_valid_d    = ifid_valid_q;
      addr_err_d      = addr_err_q;
      if (redirect_valid) begin
         pc_d            = redirect_target & PC_MASK;
         ifid_pc_d       = 32'h0;
         ifid_pc_plus4_d = 32'h0;
         ifid_instr_d    = NOP_WORD;
         ifid_valid_d    = 1'b0;
         if ((redirect_target[1:0] != 2'b00) || (redirect_target >= IM_LIMIT)) begin
            addr_err_d = 1'b1;
         end
      end else if (flush) begin
         // PC held so the killed address is fetched again next cycle.
         ifid_pc_d       = 32'h0;
         ifid_pc_plus4_d = 32'h0;
         ifid_instr_d    = NOP_WORD;
         ifid_valid_d    = 1'b0;
      end else if (!stall) begin
         pc_d            = pc_plus4;
         ifid_pc_d       = pc_q;
         ifid_pc_plus4_d = pc_plus4;
         ifid_instr_d    = Instruction;
         ifid_valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q            <= RESET_PC & PC_MASK;
         ifid_pc_q       <= 32'h0;
         ifid_pc_plus4_q <= 32'h0;
         ifid_instr_q    <= NOP_WORD;
         ifid_valid_q    <= 1'b0;
         addr_err_q      <= 1'b0;
      end else begin
         pc_q            <= pc_d;
         ifid_pc_q       <= ifid_pc_d;
         ifid_pc_plus4_q <= ifid_pc_plus4_d;
         ifid_instr_q    <= ifid_instr_d;
         ifid_valid_q    <= ifid_valid_d;
         addr_err_q      <= addr_err_d;
      end
   end

   assign InstrAddr     = pc_q;
   assign ifid_pc       = ifid_pc_q;
   assign ifid_pc_plus4 = ifid_pc_plus4_q;
   assign ifid_instr    = ifid_instr_q;
   assign ifid_valid    = ifid_valid_q;
   assign addr_err      = addr_err_q;

`ifdef IF_STAGE_PERF_CNT_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] stall_count_q, stall_count_d;

   // Saturating event counters.
   always_comb begin
      fetch_count_d = fetch_count_q;
      stall_count_d = stall_count_q;
      if (!redirect_valid && !flush && !stall && (fetch_count_q != 32'hFFFF_FFFF)) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end
      if (!redirect_valid && !flush && stall && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count_q <= 32'h0;
         stall_count_q <= 32'h0;
      end else begin
         fetch_count_q <= fetch_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fetch_count = fetch_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed scenarios then random stall/flush/redirect/reset traffic.
// Counter checks are compiled in when IF_STAGE_PERF_CNT_EN is defined.
module tb_if_stage;

   localparam int unsigned IM_BYTES = 128;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] NOP_WORD = 32'h0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] ipc;
      logic [31:0] ipc4;
      logic [31:0] instr;
      logic        valid;
      logic        err;
      logic [31:0] fc;
      logic [31:0] sc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0, stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic [31:0] InstrAddr, Instruction;
   logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr;
   logic        ifid_valid, addr_err;
`ifdef IF_STAGE_PERF_CNT_EN
   logic [31:0] fetch_count, stall_count;
`endif

   logic [31:0] mem [IM_BYTES/4];
   exp_t        sbq [$];
   int          total = 0;
   int          bad = 0;

   // Reference model state
   longint unsigned m_pc, m_ipc, m_ipc4, m_fc, m_sc;
   logic [31:0]     m_instr;
   logic            m_valid, m_err;

   if_stage #(.RESET_PC(RESET_PC), .IM_BYTES(IM_BYTES), .NOP_WORD(NOP_WORD)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .InstrAddr(InstrAddr), .Instruction(Instruction),
      .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr),
      .ifid_valid(ifid_valid), .addr_err(addr_err)
`ifdef IF_STAGE_PERF_CNT_EN
      , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   assign Instruction = mem[InstrAddr[6:2]];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Monitor: compare DUT state just after each edge against the queued expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("InstrAddr", InstrAddr, e.addr);
         chk("ifid_pc", ifid_pc, e.ipc);
         chk("ifid_pc_plus4", ifid_pc_plus4, e.ipc4);
         chk("ifid_instr", ifid_instr, e.instr);
         chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
         chk("addr_err", 32'(addr_err), 32'(e.err));
`ifdef IF_STAGE_PERF_CNT_EN
         chk("fetch_count", fetch_count, e.fc);
         chk("stall_count", stall_count, e.sc);
`endif
      end
   end

   function automatic void model_bubble();
      m_ipc = 0; m_ipc4 = 0; m_instr = NOP_WORD; m_valid = 1'b0;
   endfunction

   // Drive one cycle of inputs, advance the model, queue the expected post-edge state.
   task automatic step(input logic r, input logic s, input logic f,
                       input logic rv, input logic [31:0] t);
      exp_t e;
      @(negedge clk);
      rst = r; stall = s; flush = f; redirect_valid = rv; redirect_target = t;
      if (r) begin
         m_pc = longint'(RESET_PC) % IM_BYTES;
         model_bubble();
         m_err = 1'b0; m_fc = 0; m_sc = 0;
      end else if (rv) begin
         if ((t % 4 != 0) || (longint'(t) >= IM_BYTES)) m_err = 1'b1;
         m_pc = ((longint'(t) / 4) * 4) % IM_BYTES;
         model_bubble();
      end else if (f) begin
         model_bubble();
      end else if (s) begin
         if (m_sc < 64'hFFFF_FFFF) m_sc++;
      end else begin
         m_ipc   = m_pc;
         m_ipc4  = (m_pc + 4) % IM_BYTES;
         m_instr = mem[m_pc / 4];
         m_valid = 1'b1;
         m_pc    = m_ipc4;
         if (m_fc < 64'hFFFF_FFFF) m_fc++;
      end
      e.addr = 32'(m_pc); e.ipc = 32'(m_ipc); e.ipc4 = 32'(m_ipc4);
      e.instr = m_instr; e.valid = m_valid; e.err = m_err;
      e.fc = 32'(m_fc); e.sc = 32'(m_sc);
      sbq.push_back(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      m_pc = 0; m_ipc = 0; m_ipc4 = 0; m_instr = NOP_WORD;
      m_valid = 1'b0; m_err = 1'b0; m_fc = 0; m_sc = 0;
      for (int i = 0; i < IM_BYTES/4; i++) mem[i] = $urandom;
      mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222; mem[2] = 32'h3333_3333;

      // Reset then free-run fetch
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      run(2);
      // Stall while fetching address 8, then release
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      run(2);
      // Redirect wins over a simultaneous stall
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
      run(1);
      // Flush wins over stall and refetches the same address
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      run(1);
      // Wrap-around from the last word
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h70);
      run(5);
      // Illegal target: aligned and wrapped, sticky error until reset
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h83);
      run(10);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      // Counter scenario: 5 normal, 3 stall, 1 flush, reset mid-stall
      run(5);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      run(1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 63) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 9) == 0),
              32'($urandom_range(0, 255)));
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage directly upstream of the instruction memory and downstream-feeding the decoder. Owns the program counter and drives the byte address to the combinational, big-endian instruction memory. Captures the returned 32-bit word, with its PC, into the IF/ID pipeline register. Handles stall, flush and branch/jump redirect from later stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IM_BYTES, 128, instruction memory size in bytes; power of two; all PCs are taken modulo IM_BYTES
NOP_WORD, 32'h0000_0000, instruction value placed in IF/ID for a bubble

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hazard stall from decode; hold PC and IF/ID
flush  input  1  kill the instruction being fetched; IF/ID becomes a bubble
redirect_valid  input  1  taken branch/jump; load redirect_target into PC
redirect_target  input  32  new fetch byte address
InstrAddr  output  32  byte address to instruction memory (combinational from PC)
Instruction  input  32  word returned by instruction memory, same cycle
ifid_pc  output  32  PC of the instruction held in IF/ID
ifid_pc_plus4  output  32  (ifid_pc + 4) mod IM_BYTES
ifid_instr  output  32  instruction held in IF/ID
ifid_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble
addr_err  output  1  sticky flag: an illegal redirect target was seen

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC; ifid_valid=0, ifid_instr=NOP_WORD, ifid_pc=0, ifid_pc_plus4=0; addr_err=0. rst overrides every other input.
- InstrAddr = pc continuously. pc always word-aligned and < IM_BYTES; upper bits zero.
- Fetch latency: IM read is combinational, so the word at pc is captured into IF/ID at the same edge that advances pc. IF/ID outputs are valid 1 cycle after the address is presented.
- Per-edge priority: rst > redirect_valid > flush > stall > normal.
- Normal: IF/ID <= {pc, (pc+4) mod IM_BYTES, Instruction, valid=1}; pc <= (pc+4) mod IM_BYTES.
- redirect_valid=1, regardless of stall/flush:
  - pc <= {redirect_target[31:2],2'b00} mod IM_BYTES.
  - IF/ID <= bubble: valid=0, instr=NOP_WORD, pc fields 0.
- flush=1, no redirect: IF/ID <= bubble; pc held, so the same address is refetched next cycle. flush wins over stall.
- stall=1, no redirect/flush: pc and all IF/ID outputs hold their values.
- Wrap-around: pc=IM_BYTES-4 advances to 0. ifid_pc_plus4 wraps identically.
- addr_err: set at an edge with redirect_valid=1 and either redirect_target[1:0]!=0 or redirect_target>=IM_BYTES. Stays 1 until rst. The redirect is still taken, aligned and wrapped.
- No X propagation: bubbles carry NOP_WORD, never the memory output.

Optional Feature:
- Macro: IF_STAGE_PERF_CNT_EN.
- Defined: adds outputs fetch_count (32) and stall_count (32).
  - fetch_count increments on every edge that loads IF/ID with valid=1.
  - stall_count increments on every edge where stall=1 and neither redirect nor flush is asserted.
  - Both saturate at 32'hFFFF_FFFF and clear to 0 on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, IM words 0x11111111/0x22222222/0x33333333 at 0/4/8, 3 free cycles -> InstrAddr 0,4,8,12; ifid (pc,instr) = (0,0x11111111),(4,0x22222222),(8,0x33333333); ifid_valid=1 from cycle 1.
- Stall=1 for 2 cycles while InstrAddr=8 -> InstrAddr stays 8, ifid_pc stays 4; release -> ifid_pc=8, InstrAddr=12.
- redirect_valid=1, target 0x40, stall=1 same cycle -> next InstrAddr=0x40, ifid_valid=0, ifid_instr=0; following cycle ifid_pc=0x40, valid=1.
- Run to pc=124 -> next InstrAddr=0, ifid_pc=124, ifid_pc_plus4=0.
- Redirect target 0x83 -> InstrAddr=0x00, addr_err=1 and still 1 after 10 cycles; rst -> addr_err=0, InstrAddr=RESET_PC.
- With IF_STAGE_PERF_CNT_EN: 5 normal + 3 stall + 1 flush cycles -> fetch_count=5, stall_count=3; rst mid-stall -> both 0 next cycle.
